// File: rtl/shot_pool.sv
// Multi-bullet manager for the player's shots: launches from the rocket X, moves
// every live bullet up on each frame tick and serialises erase/draw plots.
module shot_pool #(
  parameter int NUM_SHOTS = 4,
  parameter int IDX_W = 2,
  parameter int START_Y = 105,
  parameter int STEP = 5,
  parameter int COOLDOWN = 6,
  parameter logic [2:0] DRAW_COL = 3'b111
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     fire,
  input  logic [7:0]               xin,
  input  logic                     hit_valid,
  input  logic [IDX_W-1:0]         hit_idx,
  output logic [7:0]               draw_x,
  output logic [6:0]               draw_y,
  output logic [2:0]               colour,
  output logic                     draw_en,
  output logic                     busy,
  output logic [NUM_SHOTS-1:0]     active_mask,
  output logic [8*NUM_SHOTS-1:0]   shots_x,
  output logic [7*NUM_SHOTS-1:0]   shots_y,
  output logic                     overrun
);

  localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

  typedef enum logic [2:0] {IDLE, HIT_ERASE, SCAN_ERASE, SCAN_DRAW, LAUNCH} state_t;

  state_t                 state, state_nx;
  logic [7:0]             sx [NUM_SHOTS];
  logic [6:0]             sy [NUM_SHOTS];
  logic [NUM_SHOTS-1:0]   active, pend_hit, pend_hit_nx;
  logic                   pend_tick, pend_fire;
  logic [CD_W-1:0]        cooldown;
  logic [IDX_W-1:0]       scan_idx, hit_tgt, free_idx;
  logic                   scan_last, can_launch, tick_clr, scan_survive;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_SHOTS-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_SHOTS - 1; i >= 0; i--)
      if (v[i]) lowest_idx = IDX_W'(i);
  endfunction

  always_comb begin
    hit_tgt      = lowest_idx(pend_hit);
    free_idx     = lowest_idx(~active);
    scan_last    = (scan_idx == IDX_W'(NUM_SHOTS - 1));
    can_launch   = (cooldown == '0) && !(&active);
    tick_clr     = (state == IDLE) && (pend_hit == '0) && pend_tick;
    scan_survive = active[scan_idx] && (sy[scan_idx] >= 7'(STEP));
  end

  // A hit report arriving in the same cycle as its own service wins over the clear
  always_comb begin
    pend_hit_nx = pend_hit;
    if (state == HIT_ERASE) pend_hit_nx[hit_tgt] = 1'b0;
    if (hit_valid && (int'(hit_idx) < NUM_SHOTS)) pend_hit_nx[hit_idx] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (pend_hit != '0)  state_nx = HIT_ERASE;
        else if (pend_tick)  state_nx = SCAN_ERASE;
        else if (pend_fire)  state_nx = LAUNCH;
      end
      HIT_ERASE:  state_nx = IDLE;
      SCAN_ERASE: begin
        if (scan_survive)    state_nx = SCAN_DRAW;
        else if (scan_last)  state_nx = IDLE;
        else                 state_nx = SCAN_ERASE;
      end
      SCAN_DRAW:  state_nx = scan_last ? IDLE : SCAN_ERASE;
      LAUNCH:     state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      active    <= '0;
      pend_hit  <= '0;
      pend_tick <= 1'b0;
      pend_fire <= 1'b0;
      cooldown  <= '0;
      scan_idx  <= '0;
      overrun   <= 1'b0;
      draw_en   <= 1'b0;
      colour    <= 3'b000;
      draw_x    <= 8'd0;
      draw_y    <= 7'd0;
      for (int i = 0; i < NUM_SHOTS; i++) begin
        sx[i] <= 8'd0;
        sy[i] <= 7'(START_Y);
      end
    end else begin
      state    <= state_nx;
      busy     <= (state_nx != IDLE);
      draw_en  <= 1'b0;
      pend_hit <= pend_hit_nx;

      // Overrun only counts a tick that lands on one still waiting for service
      if (tick && pend_tick && !tick_clr) overrun <= 1'b1;
      if (tick_clr) pend_tick <= 1'b0;
      if (tick)     pend_tick <= 1'b1;
      if (state == LAUNCH) pend_fire <= 1'b0;
      if (fire)            pend_fire <= 1'b1;

      case (state)
        IDLE: begin
          if (tick_clr) begin
            scan_idx <= '0;
            if (cooldown != '0) cooldown <= cooldown - CD_W'(1);
          end
        end
        HIT_ERASE: begin
          if (active[hit_tgt]) begin
            draw_en         <= 1'b1;
            colour          <= 3'b000;
            draw_x          <= sx[hit_tgt];
            draw_y          <= sy[hit_tgt];
            active[hit_tgt] <= 1'b0;
          end
        end
        SCAN_ERASE: begin
          if (active[scan_idx]) begin
            draw_en <= 1'b1;
            colour  <= 3'b000;
            draw_x  <= sx[scan_idx];
            draw_y  <= sy[scan_idx];
            if (scan_survive) begin
              sy[scan_idx] <= sy[scan_idx] - 7'(STEP);
            end else begin
              active[scan_idx] <= 1'b0;
              sy[scan_idx]     <= 7'(START_Y);
            end
          end
          if (state_nx == SCAN_ERASE) scan_idx <= scan_idx + IDX_W'(1);
        end
        SCAN_DRAW: begin
          draw_en  <= 1'b1;
          colour   <= DRAW_COL;
          draw_x   <= sx[scan_idx];
          draw_y   <= sy[scan_idx];
          scan_idx <= scan_idx + IDX_W'(1);
        end
        LAUNCH: begin
          if (can_launch) begin
            active[free_idx] <= 1'b1;
            sx[free_idx]     <= xin;
            sy[free_idx]     <= 7'(START_Y);
            cooldown         <= CD_W'(COOLDOWN);
            draw_en          <= 1'b1;
            colour           <= DRAW_COL;
            draw_x           <= xin;
            draw_y           <= 7'(START_Y);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    active_mask = active;
    shots_x     = '0;
    shots_y     = '0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      shots_x[8*i +: 8] = sx[i];
      shots_y[7*i +: 7] = sy[i];
    end
  end

endmodule
